// File: rtl/acc_drain_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain_reader_pkg
// Purpose  : Shared widths, FSM encoding and the narrow/saturate helper for
//            the accumulator drain reader.
// Revision : 1.0 - initial release
// ============================================================================
package acc_drain_reader_pkg;

    localparam int ACC_W_DFLT = 34;
    localparam int OUT_W_DFLT = 32;

    // Working width for the narrow helper; any ACC_W/OUT_W up to this fits.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } acc_state_t;

    // Result packs {sat, data} with sat sitting directly above the out_w
    // data bits, so a caller keeps {sat, data} with an (out_w+1)-bit cast.
    function automatic logic [MAX_W:0] narrow_word(
        input logic signed [MAX_W-1:0] word,
        input int unsigned             out_w,
        input logic                    sat_en
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        logic        [MAX_W-1:0] mask;
        logic        [MAX_W-1:0] data;
        logic                    sat;
        hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (out_w - 1));
        mask = (64'd1 << out_w) - 64'd1;
        sat  = 1'b0;
        data = word;
        if (sat_en) begin
            if (word > hi) begin
                sat  = 1'b1;
                data = hi;
            end else if (word < lo) begin
                sat  = 1'b1;
                data = lo;
            end
        end
        data = data & mask;
        return {1'b0, data} | ({{MAX_W{1'b0}}, sat} << out_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_drain_reader_snapshot_bank.sv
`default_nettype none
// ============================================================================
// Module   : acc_snapshot_bank
// Purpose  : NUM_ACC x ACC_W capture registers with load enable and an
//            index-selected read port.
// Revision : 1.0 - initial release
// ============================================================================
module acc_snapshot_bank
    import acc_drain_reader_pkg::*;
#(
    parameter int NUM_ACC = 8,
    parameter int ACC_W   = ACC_W_DFLT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic [NUM_ACC*ACC_W-1:0]   i_acc_flat,
    input  logic [$clog2(NUM_ACC)-1:0] i_rd_sel,
    output logic [ACC_W-1:0]           o_rd_word
);

    localparam int c_idx_w = $clog2(NUM_ACC);

    logic [ACC_W-1:0] w_words [NUM_ACC];

    for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_word
        logic [ACC_W-1:0] r_word;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (i_load) begin
                r_word <= i_acc_flat[gi*ACC_W +: ACC_W];
            end
        end

        assign w_words[gi] = r_word;
    end

    // Out-of-range selects (non power-of-two NUM_ACC) read as zero.
    always_comb begin
        o_rd_word = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (i_rd_sel == c_idx_w'(i)) begin
                o_rd_word = w_words[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_drain_reader.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain_reader
// Purpose  : Snapshots the accumulator bank on start and streams each word,
//            narrowed to OUT_W, over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module acc_drain_reader
    import acc_drain_reader_pkg::*;
#(
    parameter int NUM_ACC = 8,
    parameter int ACC_W   = ACC_W_DFLT,
    parameter int OUT_W   = OUT_W_DFLT,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic                       C,
    input  logic                       Rn,
    input  logic                       start,
    input  logic [NUM_ACC*ACC_W-1:0]   acc_flat,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(NUM_ACC)-1:0] out_idx,
    output logic                       out_last,
    output logic                       out_sat,
    output logic                       done
);

    localparam int                 c_idx_w    = $clog2(NUM_ACC);
    localparam int                 c_ext_w    = MAX_W - ACC_W;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_ACC - 1);

    acc_state_t          r_state;
    logic                r_busy;
    logic                r_valid;
    logic [OUT_W-1:0]    r_data;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_last;
    logic                r_sat;
    logic                r_done;

    logic                w_load;
    logic [c_idx_w-1:0]  w_next_idx;
    logic [ACC_W-1:0]    w_rd_word;
    logic signed [MAX_W-1:0] w_first_ext;
    logic signed [MAX_W-1:0] w_next_ext;
    logic [OUT_W:0]      w_first_nar;
    logic [OUT_W:0]      w_next_nar;

    assign w_load     = (r_state == IDLE) && start;
    assign w_next_idx = r_idx + 1'b1;

    acc_snapshot_bank #(
        .NUM_ACC (NUM_ACC),
        .ACC_W   (ACC_W)
    ) u_bank (
        .clk        (C),
        .rst_n      (Rn),
        .i_load     (w_load),
        .i_acc_flat (acc_flat),
        .i_rd_sel   (w_next_idx),
        .o_rd_word  (w_rd_word)
    );

    // Word 0 is narrowed straight from acc_flat so it appears one cycle after
    // start; later words come from the bank, looked up one index ahead.
    always_comb begin
        w_first_ext = {{c_ext_w{acc_flat[ACC_W-1]}}, acc_flat[ACC_W-1:0]};
        w_next_ext  = {{c_ext_w{w_rd_word[ACC_W-1]}}, w_rd_word};
        w_first_nar = (OUT_W+1)'(narrow_word(w_first_ext, OUT_W, SAT_EN));
        w_next_nar  = (OUT_W+1)'(narrow_word(w_next_ext, OUT_W, SAT_EN));
    end

    always_ff @(posedge C or negedge Rn) begin
        if (!Rn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state         <= STREAM;
                        r_busy          <= 1'b1;
                        r_valid         <= 1'b1;
                        r_idx           <= '0;
                        r_last          <= 1'b0;
                        {r_sat, r_data} <= w_first_nar;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx           <= w_next_idx;
                            r_last          <= (w_next_idx == c_last_idx);
                            {r_sat, r_data} <= w_next_nar;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_sat   = r_sat;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acc_drain_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_drain_reader
// Purpose  : Self-checking bench for acc_drain_reader against a plain
//            arithmetic model of the drain sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_drain_reader;

    localparam int NUM_ACC = 8;
    localparam int ACC_W   = 34;
    localparam int OUT_W   = 32;

    logic                     C;
    logic                     Rn;
    logic                     start;
    logic [NUM_ACC*ACC_W-1:0] acc_flat;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [2:0]               out_idx;
    logic                     out_last;
    logic                     out_sat;
    logic                     done;

    int checks   = 0;
    int failures = 0;

    logic [ACC_W-1:0] snap [NUM_ACC];

    acc_drain_reader #(
        .NUM_ACC (NUM_ACC),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SAT_EN  (1'b1)
    ) dut (
        .C         (C),
        .Rn        (Rn),
        .start     (start),
        .acc_flat  (acc_flat),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .done      (done)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Reference narrowing: signed value range test in plain integer arithmetic.
    function automatic logic [32:0] model(input logic [ACC_W-1:0] w);
        longint v;
        v = $signed(w);
        if (v > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, v[31:0]};
    endfunction

    function automatic logic [ACC_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: return r[ACC_W-1:0];
            1: return ACC_W'($signed(r[15:0]));
            2: case (r[1:0])
                   2'd0: return 34'h0_7FFF_FFFF;
                   2'd1: return 34'h0_8000_0000;
                   2'd2: return 34'h3_8000_0000;
                   default: return 34'h3_7FFF_FFFF;
               endcase
            default: return ACC_W'($signed(r[32:0]));
        endcase
    endfunction

    task automatic load_flat();
        for (int i = 0; i < NUM_ACC; i++) acc_flat[i*ACC_W +: ACC_W] = snap[i];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_idx"},   out_idx,   0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_sat"},   out_sat,   0);
        check({tag, "_done"},  done,      0);
    endtask

    // Start a drain of snap[] and consume it with out_ready asserted ready_pct%
    // of cycles; disturb scrambles acc_flat and pulses start while busy.
    task automatic drain(input int ready_pct, input bit disturb, output int cycles);
        int          n_xfer;
        bit          seen_done;
        logic [32:0] e;
        n_xfer    = 0;
        seen_done = 1'b0;
        cycles    = 0;
        load_flat();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", out_valid, 1);
        while (!seen_done && cycles < 300) begin
            if (out_valid) begin
                if (n_xfer < NUM_ACC) begin
                    e = model(snap[n_xfer]);
                    check("idx",  out_idx,  n_xfer);
                    check("data", out_data, e[31:0]);
                    check("sat",  out_sat,  e[32]);
                    check("last", out_last, (n_xfer == NUM_ACC - 1));
                    check("busy_stream", busy, 1);
                end else begin
                    check("extra_word", out_valid, 0);
                end
            end else begin
                check("last_when_invalid", out_last, 0);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_xfers", n_xfer, NUM_ACC);
                check("done_busy",  busy,   1);
                check("done_valid", out_valid, 0);
            end
            if (disturb) begin
                for (int i = 0; i < NUM_ACC; i++)
                    acc_flat[i*ACC_W +: ACC_W] = rand_word();
                start = (done || $urandom_range(0, 1) == 1);
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) n_xfer++;
            tick();
            cycles++;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("after_done_busy",  busy,      0);
        check("after_done_done",  done,      0);
        check("after_done_valid", out_valid, 0);
        tick();
        check("no_restart_valid", out_valid, 0);
        check("no_restart_busy",  busy,      0);
    endtask

    initial begin
        int cyc;
        int k;
        Rn        = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        acc_flat  = '0;

        // Reset is visible before any clock edge.
        #1;
        check_all_zero("reset_async");
        tick();
        tick();
        Rn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy",  busy,      0);
            check("idle_valid", out_valid, 0);
        end

        // Basic drain: word i = i+1, always ready.
        for (int i = 0; i < NUM_ACC; i++) snap[i] = ACC_W'(i + 1);
        drain(100, 1'b0, cyc);
        check("basic_cycles", cyc, NUM_ACC + 1);

        // Saturation corners.
        snap[0] = 34'h0_8000_0000;
        snap[1] = 34'h3_7FFF_FFFF;
        snap[2] = 34'h3_FFFF_FFFB;
        for (int i = 3; i < NUM_ACC; i++) snap[i] = rand_word();
        drain(100, 1'b0, cyc);

        // Random data under backpressure.
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NUM_ACC; i++) snap[i] = rand_word();
            drain(50, 1'b0, cyc);
        end

        // Snapshot isolation and start while busy.
        for (int i = 0; i < NUM_ACC; i++) snap[i] = rand_word();
        drain(60, 1'b1, cyc);

        // Reset mid-stream at idx 3.
        for (int i = 0; i < NUM_ACC; i++) snap[i] = rand_word();
        load_flat();
        start = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (!(out_valid && out_idx == 3'd3) && k < 20) begin
            tick();
            k++;
        end
        check("reach_idx3", out_idx, 3);
        #2;
        Rn = 1'b0;
        #1;
        check_all_zero("reset_mid");
        out_ready = 1'b0;
        #2;
        Rn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_done",  done,      0);
            check("post_reset_valid", out_valid, 0);
        end
        for (int i = 0; i < NUM_ACC; i++) snap[i] = rand_word();
        drain(100, 1'b0, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
